// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the cache/RAM arbiter.
// The slave modport is the arbiter's view; master is the caches-plus-RAM view.
interface cache_mem_arbiter_if #(
  parameter int NCPU = 2
);
  logic [NCPU-1:0]    iREN;
  logic [NCPU*32-1:0] iaddr;
  logic [NCPU-1:0]    iwait;
  logic [NCPU*32-1:0] iload;
  logic [NCPU-1:0]    dREN;
  logic [NCPU-1:0]    dWEN;
  logic [NCPU*32-1:0] daddr;
  logic [NCPU*32-1:0] dstore;
  logic [NCPU-1:0]    cctrans;
  logic [NCPU-1:0]    dwait;
  logic [NCPU*32-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  logic [31:0]        ramaddr;
  logic [31:0]        ramstore;
  logic [31:0]        ramload;
  logic               ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide RAM port among NCPU icaches and dcaches: dcache first,
// round-robin per side, cctrans burst lock, and an icache starvation guard.
module cache_mem_arbiter #(
  parameter int NCPU       = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RST,
  cache_mem_arbiter_if.slave bus
);

  localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    IOWN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] owner_q, owner_d;
  logic [CW-1:0] rr_d_q, rr_d_d;
  logic [CW-1:0] rr_i_q, rr_i_d;
  logic [2:0]    starve_q, starve_d;

  logic [NCPU-1:0] dreq_s;
  logic [CW:0]     d_pick_s, i_pick_s;
  logic [31:0]     iaddr_a [NCPU];
  logic [31:0]     daddr_a [NCPU];
  logic [31:0]     dstore_a [NCPU];

  function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] o);
    return (o == CW'(NCPU - 1)) ? {CW{1'b0}} : o + CW'(1);
  endfunction

  // First requester at or after start, searching cyclically; MSB = found.
  function automatic logic [CW:0] pick(input logic [NCPU-1:0] req,
                                       input logic [CW-1:0]   start);
    logic          found;
    logic [CW-1:0] idx;
    logic [CW-1:0] win;
    found = 1'b0;
    idx   = start;
    win   = start;
    for (int k = 0; k < NCPU; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = next_idx(idx);
    end
    return {found, win};
  endfunction

  for (genvar g = 0; g < NCPU; g++) begin : g_unpack
    assign iaddr_a[g]  = bus.iaddr[g*32 +: 32];
    assign daddr_a[g]  = bus.daddr[g*32 +: 32];
    assign dstore_a[g] = bus.dstore[g*32 +: 32];
  end

  assign dreq_s   = bus.dREN | bus.dWEN;
  assign d_pick_s = pick(dreq_s, rr_d_q);
  assign i_pick_s = pick(bus.iREN, rr_i_q);

  // Read data is broadcast; only the owner's wait dropping qualifies it.
  assign bus.iload = {NCPU{bus.ramload}};
  assign bus.dload = {NCPU{bus.ramload}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= {CW{1'b0}};
      rr_d_q   <= {CW{1'b0}};
      rr_i_q   <= {CW{1'b0}};
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_d_q   <= rr_d_d;
      rr_i_q   <= rr_i_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d_d       = rr_d_q;
    rr_i_d       = rr_i_q;
    starve_d     = starve_q;
    bus.iwait    = {NCPU{1'b1}};
    bus.dwait    = {NCPU{1'b1}};
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0;
    bus.ramstore = 32'h0;

    case (state_q)
      IDLE: begin
        if ((starve_q == STARVE_MAX) && (|bus.iREN)) begin
          state_d  = IOWN;
          owner_d  = i_pick_s[CW-1:0];
          starve_d = 3'd0;
        end else if (|dreq_s) begin
          state_d = DOWN;
          owner_d = d_pick_s[CW-1:0];
          if ((|bus.iREN) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (|bus.iREN) begin
          state_d  = IOWN;
          owner_d  = i_pick_s[CW-1:0];
          starve_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      DOWN: begin
        bus.ramaddr  = daddr_a[owner_q];
        bus.ramstore = dstore_a[owner_q];
        bus.ramWEN   = bus.dWEN[owner_q];
        bus.ramREN   = bus.dREN[owner_q] & ~bus.dWEN[owner_q];
        bus.dwait[owner_q] = ~(bus.ram_ready & dreq_s[owner_q]);
        // With cctrans held the owner keeps the port across words and phases.
        if (bus.cctrans[owner_q]) begin
          state_d = DOWN;
        end else if (!dreq_s[owner_q] || bus.ram_ready) begin
          state_d = IDLE;
          rr_d_d  = next_idx(owner_q);
        end else begin
          state_d = DOWN;
        end
      end

      IOWN: begin
        bus.ramaddr = iaddr_a[owner_q];
        bus.ramREN  = bus.iREN[owner_q];
        bus.iwait[owner_q] = ~(bus.ram_ready & bus.iREN[owner_q]);
        if (!bus.iREN[owner_q] || bus.ram_ready) begin
          state_d = IDLE;
          rr_i_d  = next_idx(owner_q);
        end else begin
          state_d = IOWN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a completion scoreboard: expected
// accesses are queued when driven and checked when an owner's wait drops.
module tb_cache_mem_arbiter;

  localparam int NCPU = 2;

  typedef struct {
    bit          is_i;
    int unsigned cpu;
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  int unsigned sv_cpu [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
  bit          sv_i   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  cache_mem_arbiter_if #(.NCPU(NCPU)) bus ();

  cache_mem_arbiter #(.NCPU(NCPU), .STARVE_LIM(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_i, input int unsigned cpu, input logic [31:0] addr,
                      input bit we, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i; e.cpu = cpu; e.addr = addr; e.we = we; e.data = data;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks port outputs after the current cycle's inputs settle.
  task automatic port(input string tag, input logic wen, input logic ren,
                      input logic [31:0] addr, input logic [1:0] dw, input logic [1:0] iw);
    #1;
    chk({tag, "_strb"}, {30'd0, bus.ramWEN, bus.ramREN}, {30'd0, wen, ren});
    chk({tag, "_addr"}, bus.ramaddr, addr);
    chk({tag, "_wait"}, {28'd0, bus.dwait, bus.iwait}, {28'd0, dw, iw});
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.cctrans = '0;
    bus.ramload = 32'h0; bus.ram_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    rst = 1'b0;
  endtask

  // Scoreboard: every completion pops and matches the oldest expected access.
  always @(negedge clk) begin
    for (int c = 0; c < NCPU; c++) begin
      if (bus.dwait[c] === 1'b0 || bus.iwait[c] === 1'b0) begin
        exp_t e;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_kind", {31'd0, bus.iwait[c] === 1'b0}, {31'd0, e.is_i});
          chk("sb_cpu", c, e.cpu);
          chk("sb_addr", bus.ramaddr, e.addr);
          chk("sb_we", {31'd0, bus.ramWEN}, {31'd0, e.we});
          if (e.is_i) chk("sb_iload", bus.iload[c*32 +: 32], e.data);
          else if (e.we) chk("sb_store", bus.ramstore, e.data);
          else chk("sb_dload", bus.dload[c*32 +: 32], e.data);
        end
      end
    end
  end

  initial begin
    // Reset held with requests active, then aborted mid-transaction.
    rst = 1'b1;
    clear_inputs();
    bus.dREN = 2'b11; bus.iREN = 2'b11;
    bus.daddr[0 +: 32] = 32'h10; bus.daddr[32 +: 32] = 32'h20;
    cyc(); port("rst_hold1", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("rst_hold2", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); rst = 1'b0; port("rst_rel_idle", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("rst_first_grant", 1'b0, 1'b1, 32'h10, 2'b11, 2'b11);
    rst = 1'b1;
    cyc(); bus.ram_ready = 1'b1; port("rst_abort", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    do_reset();

    // Single dcache read.
    bus.dREN = 2'b01; bus.daddr[0 +: 32] = 32'h100;
    push(1'b0, 0, 32'h100, 1'b0, 32'hDEADBEEF);
    port("rd_idle", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("rd_grant", 1'b0, 1'b1, 32'h100, 2'b11, 2'b11);
    cyc(); bus.ram_ready = 1'b1; bus.ramload = 32'hDEADBEEF;
    port("rd_done", 1'b0, 1'b1, 32'h100, 2'b10, 2'b11);
    chk("rd_dload0", bus.dload[0 +: 32], 32'hDEADBEEF);
    cyc(); bus.dREN = 2'b00; bus.ram_ready = 1'b0;
    port("rd_release", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    chk("rd_sb_empty", sb.size(), 32'd0);

    // Round-robin between two continuously requesting dcaches.
    do_reset();
    bus.dREN = 2'b11; bus.ram_ready = 1'b1; bus.ramload = 32'h5A5A5A5A;
    bus.daddr[0 +: 32] = 32'h10; bus.daddr[32 +: 32] = 32'h20;
    push(1'b0, 0, 32'h10, 1'b0, 32'h5A5A5A5A);
    push(1'b0, 1, 32'h20, 1'b0, 32'h5A5A5A5A);
    push(1'b0, 0, 32'h10, 1'b0, 32'h5A5A5A5A);
    port("rr_c0", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k % 2 == 1)
        port($sformatf("rr_c%0d", k), 1'b0, 1'b1, (k == 3) ? 32'h20 : 32'h10,
             (k == 3) ? 2'b01 : 2'b10, 2'b11);
      else
        port($sformatf("rr_c%0d", k), 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    end
    cyc(); bus.dREN = 2'b00; port("rr_c6", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("rr_c7", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    chk("rr_sb_empty", sb.size(), 32'd0);

    // Burst lock: WB then RD on cpu0 with cpu1 pending.
    do_reset();
    bus.ram_ready = 1'b1; bus.ramload = 32'h0BADF00D;
    bus.dREN = 2'b11; bus.dWEN = 2'b01; bus.cctrans = 2'b01;
    bus.daddr[0 +: 32] = 32'h200; bus.dstore[0 +: 32] = 32'hA0;
    bus.daddr[32 +: 32] = 32'h300;
    push(1'b0, 0, 32'h200, 1'b1, 32'hA0);
    push(1'b0, 0, 32'h204, 1'b1, 32'hA1);
    push(1'b0, 0, 32'h400, 1'b0, 32'h0BADF00D);
    push(1'b0, 0, 32'h404, 1'b0, 32'h0BADF00D);
    push(1'b0, 1, 32'h300, 1'b0, 32'h0BADF00D);
    port("bl_idle0", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("bl_wb0", 1'b1, 1'b0, 32'h200, 2'b10, 2'b11);
    cyc(); bus.daddr[0 +: 32] = 32'h204; bus.dstore[0 +: 32] = 32'hA1;
    port("bl_wb1", 1'b1, 1'b0, 32'h204, 2'b10, 2'b11);
    cyc(); bus.dWEN = 2'b00; bus.daddr[0 +: 32] = 32'h400;
    port("bl_rd0", 1'b0, 1'b1, 32'h400, 2'b10, 2'b11);
    cyc(); bus.daddr[0 +: 32] = 32'h404; bus.cctrans = 2'b00;
    port("bl_rd1", 1'b0, 1'b1, 32'h404, 2'b10, 2'b11);
    cyc(); bus.dREN = 2'b10; port("bl_idle1", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("bl_cpu1", 1'b0, 1'b1, 32'h300, 2'b01, 2'b11);
    cyc(); bus.dREN = 2'b00; port("bl_idle2", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    chk("bl_sb_empty", sb.size(), 32'd0);

    // Starvation guard: icache1 wins every 5th decision, counter restarts.
    do_reset();
    bus.dREN = 2'b11; bus.iREN = 2'b10; bus.ram_ready = 1'b1; bus.ramload = 32'h12345678;
    bus.daddr[0 +: 32] = 32'h10; bus.daddr[32 +: 32] = 32'h20; bus.iaddr[32 +: 32] = 32'h800;
    for (int k = 0; k < 10; k++)
      push(sv_i[k], sv_cpu[k], sv_i[k] ? 32'h800 : (sv_cpu[k] == 1 ? 32'h20 : 32'h10),
           1'b0, 32'h12345678);
    port("sv_idle0", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    for (int k = 0; k < 10; k++) begin
      cyc();
      port($sformatf("sv_grant%0d", k), 1'b0, 1'b1,
           sv_i[k] ? 32'h800 : (sv_cpu[k] == 1 ? 32'h20 : 32'h10),
           sv_i[k] ? 2'b11 : (sv_cpu[k] == 1 ? 2'b01 : 2'b10),
           sv_i[k] ? 2'b01 : 2'b11);
      cyc();
      if (k == 9) begin
        bus.dREN = 2'b00; bus.iREN = 2'b00;
      end
      port($sformatf("sv_idle%0d", k + 1), 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    end
    chk("sv_sb_empty", sb.size(), 32'd0);

    // Abandon: cpu1 drops its write before ram_ready.
    do_reset();
    bus.dWEN = 2'b10; bus.daddr[32 +: 32] = 32'h600; bus.dstore[32 +: 32] = 32'h66;
    port("ab_idle0", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("ab_grant", 1'b1, 1'b0, 32'h600, 2'b11, 2'b11);
    cyc(); bus.dWEN = 2'b00; port("ab_drop", 1'b0, 1'b0, 32'h600, 2'b11, 2'b11);
    cyc(); bus.dREN = 2'b11; bus.daddr[0 +: 32] = 32'h700;
    port("ab_idle1", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    cyc(); port("ab_rr_d0", 1'b0, 1'b1, 32'h700, 2'b11, 2'b11);
    cyc(); bus.dREN = 2'b00; port("ab_release", 1'b0, 1'b0, 32'h700, 2'b11, 2'b11);
    cyc(); port("ab_final", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    chk("ab_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
